ps2_key_event_queue: RTL and testbench

//   Downstream of the PS/2 receiver: consumes raw scan-code bytes and their done strobe.

---
 rtl/ps2_key_event_queue.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue
//   Turns the raw Set-2 scan-code byte stream from a PS/2 receiver into single
//   key events {brk, ext, code}. It can optionally drop typematic repeats, and it
//   queues the events in a show-ahead FIFO that the application drains at its own pace.
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   byte_in    scan-code byte, qualified by byte_tick
//   byte_tick  one-cycle strobe: byte_in holds a new byte
//   rd_en      pop the head event (ignored while empty)
//   clr_ovf    clear the sticky overflow flag
//   ev_data    head event [9]=brk [8]=ext [7:0]=code, valid while empty=0
//   empty      no events stored
//   full       DEPTH events stored
//   count      number of stored events, 0..DEPTH
//   overflow   sticky: an event was lost because the FIFO was full
module ps2_key_event_queue #(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_tick,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [9:0]        ev_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                emit_s, ev_brk_s, ev_ext_s;
    logic [9:0]          ev_s;
    logic                push_req_s, last_load_s, last_clr_s;
    logic                pop_s, push_acc_s, ovf_set_s;
    logic [8:0]          last_key_r;
    logic                last_vld_r;
    logic [9:0]          mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [ADDR_W:0]     count_r, count_nxt_s;
    logic                empty_r, full_r, overflow_r;
    logic [9:0]          ev_data_r;

    // Prefix decoder: E0/F0 accumulate in the state, data bytes emit an event.
    always_comb begin
        state_nxt_s = state_r;
        emit_s      = 1'b0;
        ev_brk_s    = 1'b0;
        ev_ext_s    = 1'b0;
        if (byte_tick) begin
            case (byte_in)
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                    // Device responses/errors abort any partial sequence.
                    state_nxt_s = ST_IDLE;
                end
                8'hE1: begin
                    // Pause prefix is swallowed; its payload decodes as ordinary bytes.
                    state_nxt_s = state_r;
                end
                8'hE0: begin
                    case (state_r)
                        ST_IDLE:    state_nxt_s = ST_EXT;
                        ST_EXT:     state_nxt_s = ST_EXT;
                        ST_BRK:     state_nxt_s = ST_EXT_BRK;
                        ST_EXT_BRK: state_nxt_s = ST_EXT_BRK;
                        default:    state_nxt_s = ST_IDLE;
                    endcase
                end
                8'hF0: begin
                    case (state_r)
                        ST_IDLE:    state_nxt_s = ST_BRK;
                        ST_EXT:     state_nxt_s = ST_EXT_BRK;
                        ST_BRK:     state_nxt_s = ST_BRK;
                        ST_EXT_BRK: state_nxt_s = ST_EXT_BRK;
                        default:    state_nxt_s = ST_IDLE;
                    endcase
                end
                default: begin
                    emit_s      = 1'b1;
                    ev_brk_s    = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
                    ev_ext_s    = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign ev_s = {ev_brk_s, ev_ext_s, byte_in};

    // Repeat filter: a make matching the last make (no break since) is dropped.
    always_comb begin
        push_req_s  = 1'b0;
        last_load_s = 1'b0;
        last_clr_s  = 1'b0;
        if (emit_s) begin
            if (ev_brk_s) begin
                push_req_s = 1'b1;
                last_clr_s = 1'b1;
            end else if (FILTER_REPEAT && last_vld_r && (last_key_r == {ev_ext_s, byte_in})) begin
                push_req_s = 1'b0;
            end else begin
                push_req_s  = 1'b1;
                last_load_s = 1'b1;
            end
        end else begin
            push_req_s = 1'b0;
        end
    end

    // FIFO handshake. While full, a push is taken only when a pop frees the slot.
    always_comb begin
        pop_s      = rd_en && !empty_r;
        push_acc_s = push_req_s && (!full_r || pop_s);
        ovf_set_s  = push_req_s && full_r && !pop_s;
        rd_nxt_s   = pop_s ? (rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1}) : rd_ptr_r;
        if (push_acc_s && !pop_s) begin
            count_nxt_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
        end else if (pop_s && !push_acc_s) begin
            count_nxt_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Decoder state and last-make register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_key_r <= 9'd0;
            last_vld_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (last_clr_s) begin
                last_vld_r <= 1'b0;
            end else if (last_load_s) begin
                last_key_r <= {ev_ext_s, byte_in};
                last_vld_r <= 1'b1;
            end
        end
    end

    // Event storage; no reset needed since entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= ev_s;
        end
    end

    // Pointers, flags and the registered show-ahead head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W+1){1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            ev_data_r  <= 10'd0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            rd_ptr_r <= rd_nxt_s;
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == {(ADDR_W+1){1'b0}});
            full_r   <= (count_nxt_s == DEPTH[ADDR_W:0]);
            // A dropping push wins over a same-cycle clear.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
            // The new head bypasses memory when it is being written this same edge.
            if (push_acc_s && (wr_ptr_r == rd_nxt_s)) begin
                ev_data_r <= ev_s;
            end else begin
                ev_data_r <= mem_r[rd_nxt_s];
            end
        end
    end

    assign ev_data  = ev_data_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Self-checking bench for ps2_key_event_queue: a queue-based reference model of
// the decoder, repeat filter and FIFO, compared every cycle, plus literal checks.
module tb_ps2_key_event_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_tick = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [9:0] ev_data;
    logic       empty, full, overflow;
    logic [4:0] count;

    ps2_key_event_queue #(.DEPTH(16), .ADDR_W(4), .FILTER_REPEAT(1'b1)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_tick(byte_tick),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_data(ev_data), .empty(empty),
        .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [9:0] m_q[$];
    bit         m_ext, m_brk, m_ovf, m_lastv;
    logic [8:0] m_last;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_ctrl(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit tick, input logic [7:0] b, input bit rd, input bit clr);
        bit push, pop, was_full, set;
        logic [9:0] ev;
        push = 1'b0;
        ev = 10'd0;
        if (tick) begin
            if (is_ctrl(b)) begin
                m_ext = 1'b0; m_brk = 1'b0;
            end else if (b == 8'hE1) begin
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                ev = {m_brk, m_ext, b};
                if (m_brk) begin
                    m_lastv = 1'b0;
                    push = 1'b1;
                end else if (m_lastv && m_last == {m_ext, b}) begin
                    push = 1'b0;
                end else begin
                    push = 1'b1;
                    m_last = {m_ext, b};
                    m_lastv = 1'b1;
                end
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end
        pop = rd && (m_q.size() > 0);
        was_full = (m_q.size() == 16);
        set = push && was_full && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && (!was_full || pop)) m_q.push_back(ev);
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("empty", empty, m_q.size() == 0);
            check("full", full, m_q.size() == 16);
            check("count", count, m_q.size());
            check("overflow", overflow, m_ovf);
            if (m_q.size() > 0) check("ev_data", ev_data, m_q[0]);
        end
    end

    task automatic cyc(input bit tick, input logic [7:0] b, input bit rd, input bit clr);
        byte_tick = tick; byte_in = b; rd_en = rd; clr_ovf = clr;
        model_step(tick, b, rd, clr);
        @(posedge clk);
        @(negedge clk);
        #1;
        byte_tick = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic tick_b(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_lastv = 1'b0; m_last = 9'd0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] ctrl_tab [7];
    logic [7:0] code_tab [6];

    initial begin
        ctrl_tab = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        code_tab = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75};
        #2;
        do_reset();
        chk_en = 1'b1;
        check("rst_ev_data", ev_data, 10'h000);
        check("rst_empty", empty, 1'b1);
        check("rst_count", count, 5'd0);

        // Single make
        tick_b(8'h1C);
        check("make_ev", ev_data, 10'h01C);
        check("make_count", count, 5'd1);
        pop1();
        check("make_pop_empty", empty, 1'b1);

        // Extended break
        tick_b(8'hE0);
        tick_b(8'hF0);
        check("prefix_no_event", empty, 1'b1);
        tick_b(8'h75);
        check("ext_brk_ev", ev_data, 10'h375);
        pop1();

        // Repeat filtering
        tick_b(8'h1C); tick_b(8'h1C); tick_b(8'h1C);
        tick_b(8'hF0); tick_b(8'h1C); tick_b(8'h1C);
        check("rep_count", count, 5'd3);
        check("rep_ev0", ev_data, 10'h01C); pop1();
        check("rep_ev1", ev_data, 10'h21C); pop1();
        check("rep_ev2", ev_data, 10'h01C); pop1();
        check("rep_empty", empty, 1'b1);

        // Overflow with 17 distinct makes
        for (int i = 0; i < 17; i++) tick_b(8'h10 + 8'(i));
        check("ovf_count", count, 5'd16);
        check("ovf_full", full, 1'b1);
        check("ovf_flag", overflow, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", overflow, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("ovf_order", ev_data, {2'b00, 8'h10 + 8'(i)});
            pop1();
        end
        check("ovf_drained", empty, 1'b1);

        // Push and pop on a full FIFO
        for (int i = 0; i < 16; i++) tick_b(8'h30 + 8'(i));
        cyc(1'b1, 8'h2A, 1'b1, 1'b0);
        check("fullpp_count", count, 5'd16);
        check("fullpp_ovf", overflow, 1'b0);
        check("fullpp_head", ev_data, 10'h031);
        for (int i = 0; i < 15; i++) pop1();
        check("fullpp_tail", ev_data, 10'h02A);
        pop1();

        // Control byte aborts a prefix
        tick_b(8'hE0);
        tick_b(8'hAA);
        check("ctrl_no_event", empty, 1'b1);
        tick_b(8'h1C);
        check("ctrl_then_make", ev_data, 10'h01C);
        pop1();

        // Reset abandons a partial break
        tick_b(8'hF0);
        do_reset();
        tick_b(8'h1C);
        check("rst_mid_ev", ev_data, 10'h01C);
        pop1();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 15);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r == 4) b = 8'hE1;
            else if (r == 5) b = ctrl_tab[$urandom_range(0, 6)];
            else b = code_tab[$urandom_range(0, 5)];
            cyc(($urandom_range(0, 3) != 0), b,
                ($urandom_range(0, 7) < ((n / 500) % 2 == 0 ? 1 : 6)),
                ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
